// File: rtl/parking_lot_monitor.sv
// parking_lot_monitor
// Multi-gate parking lot occupancy monitor. Each gate has an outer and an
// inner beam sensor; a per-gate FSM recognises a complete entry
// (outer -> both -> inner -> clear) or exit (inner -> both -> outer -> clear)
// and emits a one-cycle pulse. A shared saturating counter tracks occupancy
// between 0 and CAPACITY and raises sticky flags when an event is dropped.

module parking_lot_monitor #(
  parameter int NUM_GATES = 2,
  parameter int CAPACITY  = 25,
  parameter int CNT_W     = $clog2(CAPACITY + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] outer,
  input  logic [NUM_GATES-1:0] inner,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic [NUM_GATES-1:0] enter_pulse,
  output logic [NUM_GATES-1:0] exit_pulse,
  output logic                 overflow,
  output logic                 underflow
);

  // Signed width for the next-count sum: enough headroom for +/- NUM_GATES
  localparam int SUM_W = CNT_W + 4;

  localparam logic signed [SUM_W-1:0] CAP_S = SUM_W'(CAPACITY);
  localparam logic        [CNT_W-1:0] CAP_C = CNT_W'(CAPACITY);

  // Gate FSM states. The pair {o,i} names the sensor pattern each state
  // expects: EN_* walk 10 -> 11 -> 01, EX_* walk 01 -> 11 -> 10.
  typedef enum logic [2:0] {
    IDLE,
    EN_O,
    EN_OI,
    EN_I,
    EX_I,
    EX_OI,
    EX_O,
    WAIT
  } gate_state_t;

  logic [NUM_GATES-1:0] outer_s1;
  logic [NUM_GATES-1:0] outer_s2;
  logic [NUM_GATES-1:0] inner_s1;
  logic [NUM_GATES-1:0] inner_s2;

  // Two-flop synchronisers for the raw, asynchronous sensor lines
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outer_s1 <= '0;
      outer_s2 <= '0;
      inner_s1 <= '0;
      inner_s2 <= '0;
    end else begin
      outer_s1 <= outer;
      outer_s2 <= outer_s1;
      inner_s1 <= inner;
      inner_s2 <= inner_s1;
    end
  end

  for (genvar g = 0; g < NUM_GATES; g++) begin : gen_gate
    gate_state_t state;
    logic [1:0]  pair;
    logic        enter_q;
    logic        exit_q;

    assign pair           = {outer_s2[g], inner_s2[g]};
    assign enter_pulse[g] = enter_q;
    assign exit_pulse[g]  = exit_q;

    // Direction-detect FSM with registered one-cycle entry/exit pulses
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state   <= IDLE;
        enter_q <= 1'b0;
        exit_q  <= 1'b0;
      end else begin
        enter_q <= 1'b0;
        exit_q  <= 1'b0;
        case (state)
          IDLE: begin
            case (pair)
              2'b10:   state <= EN_O;
              2'b01:   state <= EX_I;
              2'b11:   state <= WAIT;
              default: state <= IDLE;
            endcase
          end
          EN_O: begin
            case (pair)
              2'b11:   state <= EN_OI;
              2'b00:   state <= IDLE;
              2'b10:   state <= EN_O;
              default: state <= WAIT;
            endcase
          end
          EN_OI: begin
            case (pair)
              2'b01:   state <= EN_I;
              2'b10:   state <= EN_O;
              2'b11:   state <= EN_OI;
              default: state <= WAIT;
            endcase
          end
          EN_I: begin
            case (pair)
              2'b00: begin
                state   <= IDLE;
                enter_q <= 1'b1;
              end
              2'b11:   state <= EN_OI;
              2'b01:   state <= EN_I;
              default: state <= WAIT;
            endcase
          end
          EX_I: begin
            case (pair)
              2'b11:   state <= EX_OI;
              2'b00:   state <= IDLE;
              2'b01:   state <= EX_I;
              default: state <= WAIT;
            endcase
          end
          EX_OI: begin
            case (pair)
              2'b10:   state <= EX_O;
              2'b01:   state <= EX_I;
              2'b11:   state <= EX_OI;
              default: state <= WAIT;
            endcase
          end
          EX_O: begin
            case (pair)
              2'b00: begin
                state  <= IDLE;
                exit_q <= 1'b1;
              end
              2'b11:   state <= EX_OI;
              2'b10:   state <= EX_O;
              default: state <= WAIT;
            endcase
          end
          WAIT: begin
            if (pair == 2'b00) begin
              state <= IDLE;
            end else begin
              state <= WAIT;
            end
          end
          default: state <= WAIT;
        endcase
      end
    end
  end

  function automatic logic [3:0] popcount(input logic [NUM_GATES-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < NUM_GATES; k++) begin
      c = c + {3'b000, v[k]};
    end
    return c;
  endfunction

  logic [3:0]              enter_cnt;
  logic [3:0]              exit_cnt;
  logic signed [SUM_W-1:0] sum;
  logic [CNT_W-1:0]        count_next;
  logic                    ovf_hit;
  logic                    unf_hit;

  assign enter_cnt = popcount(enter_pulse);
  assign exit_cnt  = popcount(exit_pulse);
  assign sum       = $signed({4'b0000, count})
                   + $signed({{CNT_W{1'b0}}, enter_cnt})
                   - $signed({{CNT_W{1'b0}}, exit_cnt});

  // Clamp the signed next count into [0, CAPACITY] and flag any dropped event
  always_comb begin
    count_next = sum[CNT_W-1:0];
    ovf_hit    = 1'b0;
    unf_hit    = 1'b0;
    if (sum[SUM_W-1]) begin
      count_next = '0;
      unf_hit    = 1'b1;
    end else if (sum > CAP_S) begin
      count_next = CAP_C;
      ovf_hit    = 1'b1;
    end
  end

  // Occupancy register with full/empty decoded from the same next value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= count_next;
      full      <= (count_next == CAP_C);
      empty     <= (count_next == '0);
      overflow  <= overflow | ovf_hit;
      underflow <= underflow | unf_hit;
    end
  end

endmodule
